// File: rtl/if_fetch_unit_if.sv
// Instruction-cache fetch bus: request/address out, ready/rdata back (ready may be same-cycle on a hit).
interface if_fetch_unit_if;
  logic        icache_req;
  logic [31:0] icache_addr;
  logic        icache_ready;
  logic [31:0] icache_rdata;

  modport master (
    output icache_req,
    output icache_addr,
    input  icache_ready,
    input  icache_rdata
  );

  modport slave (
    input  icache_req,
    input  icache_addr,
    output icache_ready,
    output icache_rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Fetch stage: owns PC, issues I-cache requests, feeds IF/ID; 0-cycle hit, stalls while ready is low.
// Redirects during a miss wait out the pending access and drop its data. IF_PERF_CNT_EN adds perf counters.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pc_write_in,
  input  logic                   branch_taken_in,
  input  logic [31:0]            branch_target_in,
  input  logic                   jump_in,
  input  logic [31:0]            jump_target_in,
  if_fetch_unit_if.master        icache,
  output logic [31:0]            instruction_out,
  output logic [31:0]            pcCurrent_out,
  output logic                   fetch_stall_out
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]            perf_fetch_cnt,
  output logic [31:0]            perf_miss_cyc
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_DISCARD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic        redirect_pend_q, redirect_pend_d;

  logic        redirect;
  logic [31:0] redirect_target;
  logic        ready;

  assign ready    = icache.icache_ready;
  assign redirect = branch_taken_in | jump_in;

  // Branch belongs to the older instruction, so it overrides a simultaneous jump.
  always_comb begin
    redirect_target = branch_taken_in ? branch_target_in : jump_target_in;
    redirect_target[1:0] = 2'b00;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      pc_q            <= {RESET_PC[31:2], 2'b00};
      pend_target_q   <= 32'h0;
      redirect_pend_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      pend_target_q   <= pend_target_d;
      redirect_pend_q <= redirect_pend_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    pend_target_d   = pend_target_q;
    redirect_pend_d = redirect_pend_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (redirect) begin
          if (ready) begin
            pc_d = redirect_target;
          end else begin
            pend_target_d   = redirect_target;
            redirect_pend_d = 1'b1;
            state_d         = S_DISCARD;
          end
        end else if (ready && pc_write_in) begin
          pc_d = (pc_q + PC_STEP) & 32'hFFFF_FFFC;
        end
      end
      S_DISCARD: begin
        if (redirect) begin
          pend_target_d = redirect_target;
        end
        // The bus cannot abort, so the stale access must complete before moving on.
        if (ready) begin
          pc_d            = redirect ? redirect_target : pend_target_q;
          redirect_pend_d = 1'b0;
          state_d         = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  logic fetch_vld;

  always_comb begin
    icache.icache_req  = 1'b0;
    icache.icache_addr = pc_q;
    fetch_vld          = 1'b0;
    case (state_q)
      S_RUN: begin
        icache.icache_req = 1'b1;
        fetch_vld         = ready & ~redirect_pend_q;
      end
      S_DISCARD: begin
        icache.icache_req = 1'b1;
      end
      default: begin
        icache.icache_req = 1'b0;
      end
    endcase
    instruction_out = fetch_vld ? icache.icache_rdata : 32'h0;
    pcCurrent_out   = pc_q + PC_STEP;
    fetch_stall_out = ~fetch_vld;
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_miss_q, perf_miss_d;

  always_comb begin
    perf_fetch_d = perf_fetch_q;
    perf_miss_d  = perf_miss_q;
    if (state_q == S_RUN && ready && pc_write_in) begin
      perf_fetch_d = perf_fetch_q + 32'd1;
    end
    if (icache.icache_req && !ready) begin
      perf_miss_d = perf_miss_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetch_q <= 32'h0;
      perf_miss_q  <= 32'h0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_miss_q  <= perf_miss_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_miss_cyc  = perf_miss_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit; the cache returns {16'hCAFE, addr[15:0]} as instruction data.
module tb_if_fetch_unit;
  logic        clk;
  logic        reset;
  logic        pc_write_in;
  logic        branch_taken_in;
  logic [31:0] branch_target_in;
  logic        jump_in;
  logic [31:0] jump_target_in;
  logic [31:0] instruction_out;
  logic [31:0] pcCurrent_out;
  logic        fetch_stall_out;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_miss_cyc;
`endif

  int errors = 0;
  int checks = 0;

  if_fetch_unit_if ic_bus ();

  if_fetch_unit dut (
    .clk              (clk),
    .reset            (reset),
    .pc_write_in      (pc_write_in),
    .branch_taken_in  (branch_taken_in),
    .branch_target_in (branch_target_in),
    .jump_in          (jump_in),
    .jump_target_in   (jump_target_in),
    .icache           (ic_bus),
    .instruction_out  (instruction_out),
    .pcCurrent_out    (pcCurrent_out),
    .fetch_stall_out  (fetch_stall_out)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt   (perf_fetch_cnt),
    .perf_miss_cyc    (perf_miss_cyc)
`endif
  );

  assign ic_bus.icache_rdata = {16'hCAFE, ic_bus.icache_addr[15:0]};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_fetch(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                           input logic stall);
    chk({tag, "_req"},   32'(ic_bus.icache_req), 32'd1);
    chk({tag, "_addr"},  ic_bus.icache_addr, addr);
    chk({tag, "_instr"}, instruction_out, instr);
    chk({tag, "_stall"}, 32'(fetch_stall_out), 32'(stall));
  endtask

  initial begin
    reset = 1'b0;
    pc_write_in = 1'b1;
    branch_taken_in = 1'b0;
    branch_target_in = 32'h0;
    jump_in = 1'b0;
    jump_target_in = 32'h0;
    ic_bus.icache_ready = 1'b1;
    #3;
    chk("rst_req",   32'(ic_bus.icache_req), 32'd0);
    chk("rst_instr", instruction_out, 32'h0);
    chk("rst_stall", 32'(fetch_stall_out), 32'd1);
`ifdef IF_PERF_CNT_EN
    chk("rst_perf_fetch", perf_fetch_cnt, 32'h0);
    chk("rst_perf_miss",  perf_miss_cyc, 32'h0);
`endif

    // 1: sequential fetch after reset release
    tick();
    reset = 1'b1;
    #1;
    chk("idle_req",   32'(ic_bus.icache_req), 32'd0);
    chk("idle_stall", 32'(fetch_stall_out), 32'd1);
    tick(); #1;
    chk_fetch("seq0", 32'h0, 32'hCAFE_0000, 1'b0);
    chk("seq0_pcc", pcCurrent_out, 32'h4);
    tick(); #1;
    chk_fetch("seq1", 32'h4, 32'hCAFE_0004, 1'b0);
    chk("seq1_pcc", pcCurrent_out, 32'h8);
    tick(); #1;
    chk_fetch("seq2", 32'h8, 32'hCAFE_0008, 1'b0);
    chk("seq2_pcc", pcCurrent_out, 32'hC);
    tick(); #1;
    chk_fetch("seq3", 32'hC, 32'hCAFE_000C, 1'b0);
    chk("seq3_pcc", pcCurrent_out, 32'h10);

    // 2: jump back to 8, then 3-cycle miss there
    jump_in = 1'b1; jump_target_in = 32'h8;
    tick();
    jump_in = 1'b0; ic_bus.icache_ready = 1'b0;
    #1;
    chk_fetch("miss_c1", 32'h8, 32'h0, 1'b1);
    tick(); #1;
    chk_fetch("miss_c2", 32'h8, 32'h0, 1'b1);
    tick(); #1;
    chk_fetch("miss_c3", 32'h8, 32'h0, 1'b1);
    tick();
    ic_bus.icache_ready = 1'b1;
    #1;
    chk_fetch("miss_done", 32'h8, 32'hCAFE_0008, 1'b0);
    chk("miss_done_pcc", pcCurrent_out, 32'hC);
    tick(); #1;
    chk_fetch("miss_next", 32'hC, 32'hCAFE_000C, 1'b0);

    // 3: branch during a miss at 8 is deferred until the stale access completes
    jump_in = 1'b1; jump_target_in = 32'h8;
    tick();
    jump_in = 1'b0; ic_bus.icache_ready = 1'b0;
    #1;
    chk_fetch("disc_c1", 32'h8, 32'h0, 1'b1);
    tick();
    branch_taken_in = 1'b1; branch_target_in = 32'h40;
    #1;
    chk_fetch("disc_c2", 32'h8, 32'h0, 1'b1);
    tick();
    branch_taken_in = 1'b0;
    #1;
    chk_fetch("disc_c3", 32'h8, 32'h0, 1'b1);
    tick();
    ic_bus.icache_ready = 1'b1;
    #1;
    chk_fetch("disc_drop", 32'h8, 32'h0, 1'b1);
    tick(); #1;
    chk_fetch("disc_tgt", 32'h40, 32'hCAFE_0040, 1'b0);

    // 4: branch beats jump; redirect ignores pc_write_in
    branch_taken_in = 1'b1; branch_target_in = 32'h80;
    jump_in = 1'b1; jump_target_in = 32'hC0;
    tick();
    branch_taken_in = 1'b0; jump_in = 1'b0;
    #1;
    chk_fetch("prio", 32'h80, 32'hCAFE_0080, 1'b0);
    branch_taken_in = 1'b1; branch_target_in = 32'h100; pc_write_in = 1'b0;
    tick();
    branch_taken_in = 1'b0; pc_write_in = 1'b1;
    #1;
    chk_fetch("redir_nowr", 32'h100, 32'hCAFE_0100, 1'b0);

    // 5: two cycles of pc_write_in=0 at 0x10
    jump_in = 1'b1; jump_target_in = 32'h10;
    tick();
    jump_in = 1'b0; pc_write_in = 1'b0;
    #1;
    chk_fetch("hold_a", 32'h10, 32'hCAFE_0010, 1'b0);
    tick(); #1;
    chk_fetch("hold_b", 32'h10, 32'hCAFE_0010, 1'b0);
    tick();
    pc_write_in = 1'b1;
    #1;
    chk_fetch("hold_c", 32'h10, 32'hCAFE_0010, 1'b0);
    tick(); #1;
    chk_fetch("hold_rel", 32'h14, 32'hCAFE_0014, 1'b0);

    // 6: wrap, alignment, async reset mid-miss
    jump_in = 1'b1; jump_target_in = 32'hFFFF_FFFC;
    tick();
    jump_in = 1'b0;
    #1;
    chk_fetch("wrap_top", 32'hFFFF_FFFC, 32'hCAFE_FFFC, 1'b0);
    chk("wrap_pcc", pcCurrent_out, 32'h0);
    tick(); #1;
    chk_fetch("wrap_zero", 32'h0, 32'hCAFE_0000, 1'b0);
    jump_in = 1'b1; jump_target_in = 32'h23;
    tick();
    jump_in = 1'b0;
    #1;
    chk_fetch("align", 32'h20, 32'hCAFE_0020, 1'b0);
    ic_bus.icache_ready = 1'b0;
    tick(); #1;
    chk_fetch("pre_rst_miss", 32'h20, 32'h0, 1'b1);
    reset = 1'b0;
    #1;
    chk("arst_req",   32'(ic_bus.icache_req), 32'd0);
    chk("arst_stall", 32'(fetch_stall_out), 32'd1);
    chk("arst_addr",  ic_bus.icache_addr, 32'h0);
`ifdef IF_PERF_CNT_EN
    chk("arst_perf_fetch", perf_fetch_cnt, 32'h0);
    chk("arst_perf_miss",  perf_miss_cyc, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
